// File: rtl/mem_access_ctl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage sequencer and data memory.
interface mem_access_ctl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctl.sv
// MEM-stage sequencer: runs one data-memory transaction per load/store, stalls the
// pipeline until it completes, resolves taken branches and flags bad accesses.
module mem_access_ctl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              branch,
  input  logic              zero,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rdata2,
  input  logic              clr_err,
  mem_access_ctl_if.master  mem,
  output logic              stall,
  output logic              pcsrc,
  output logic              flush,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              err_align,
  output logic              err_illegal,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_q, ld_d;
  logic        lv_q, lv_d;
  logic        ea_q, ea_d;
  logic        ei_q, ei_d;
  logic        et_q, et_d;

  logic access, both, misal, legal;
  logic set_ill, set_al, set_to;

  always_comb begin
    access  = memread | memwrite;
    both    = memread & memwrite;
    misal   = (alu_result[1:0] != 2'b00);
    legal   = access & ~both & ~misal;

    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    lv_d    = 1'b0;
    set_ill = 1'b0;
    set_al  = 1'b0;
    set_to  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (legal) begin
          state_d = REQ;
          addr_d  = alu_result;
          wdata_d = rdata2;
          we_d    = memwrite;
          cnt_d   = '0;
          req_d   = 1'b1;
        end else if (both) begin
          set_ill = 1'b1;
        end else if (access) begin
          set_al  = 1'b1;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        // An ack on the final allowed cycle wins over the timeout.
        if (mem.mem_ack) begin
          if (!we_q) ld_d = mem.mem_rdata;
          lv_d    = ~we_q;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          set_to  = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ei_d = set_ill | (ei_q & ~clr_err);
    ea_d = set_al  | (ea_q & ~clr_err);
    et_d = set_to  | (et_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      lv_q    <= 1'b0;
      ea_q    <= 1'b0;
      ei_q    <= 1'b0;
      et_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      ea_q    <= ea_d;
      ei_q    <= ei_d;
      et_q    <= et_d;
    end
  end

  always_comb begin
    stall = ((state_q == IDLE) & legal) | (state_q == REQ);
    pcsrc = branch & zero & (state_q == IDLE);
    flush = pcsrc;
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign load_data     = ld_q;
  assign load_valid    = lv_q;
  assign err_align     = ea_q;
  assign err_illegal   = ei_q;
  assign err_timeout   = et_q;

endmodule

// File: tb/tb_mem_access_ctl.sv
// Bench for mem_access_ctl: transaction-level expectations per cycle, compared on every
// falling edge, plus literal checks for the directed scenarios.
module tb_mem_access_ctl;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0, branch = 1'b0, zero = 1'b0, clr_err = 1'b0;
  logic [31:0] alu_result = '0, rdata2 = '0;
  logic        stall, pcsrc, flush, load_valid, err_align, err_illegal, err_timeout;
  logic [31:0] load_data;

  mem_access_ctl_if mif();

  mem_access_ctl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
    .branch(branch), .zero(zero), .alu_result(alu_result), .rdata2(rdata2),
    .clr_err(clr_err), .mem(mif), .stall(stall), .pcsrc(pcsrc), .flush(flush),
    .load_data(load_data), .load_valid(load_valid), .err_align(err_align),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cnt_req = 0, cnt_stall = 0, cnt_lv = 0;
  bit rand_en = 1'b0;

  logic        exp_valid = 1'b0;
  logic        e_stall, e_pcsrc, e_req, e_lv, e_we, e_ea, e_ei, e_et;
  logic [31:0] e_addr, e_wd, e_ld;

  // Architectural state the outputs must reflect.
  logic        m_we = 1'b0, m_ea = 1'b0, m_ei = 1'b0, m_et = 1'b0;
  logic [31:0] m_addr = '0, m_wd = '0, m_ld = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid && rst_n) begin
      check("stall",       stall,         e_stall);
      check("pcsrc",       pcsrc,         e_pcsrc);
      check("flush",       flush,         e_pcsrc);
      check("mem_req",     mif.mem_req,   e_req);
      check("mem_we",      mif.mem_we,    e_we);
      check("mem_addr",    mif.mem_addr,  e_addr);
      check("mem_wdata",   mif.mem_wdata, e_wd);
      check("load_data",   load_data,     e_ld);
      check("load_valid",  load_valid,    e_lv);
      check("err_align",   err_align,     e_ea);
      check("err_illegal", err_illegal,   e_ei);
      check("err_timeout", err_timeout,   e_et);
      cnt_req   += int'(mif.mem_req);
      cnt_stall += int'(stall);
      cnt_lv    += int'(load_valid);
    end
  end

  function automatic logic rclr();
    return rand_en && ($urandom_range(0, 7) == 0);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic run_cycle(input logic s, p, r, lv, si, sa, st, c);
    e_stall = s; e_pcsrc = p; e_req = r; e_lv = lv;
    e_we = m_we; e_addr = m_addr; e_wd = m_wd; e_ld = m_ld;
    e_ea = m_ea; e_ei = m_ei; e_et = m_et;
    exp_valid = 1'b1;
    @(posedge clk);
    m_ei = si | (m_ei & ~c);
    m_ea = sa | (m_ea & ~c);
    m_et = st | (m_et & ~c);
    #1;
  endtask

  task automatic idle_cycle(input logic c);
    memread = 1'b0; memwrite = 1'b0; alu_result = $urandom; rdata2 = $urandom;
    branch = rbit(); zero = rbit(); mif.mem_ack = rbit(); mif.mem_rdata = $urandom;
    clr_err = c;
    run_cycle(1'b0, branch & zero, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, clr_err);
  endtask

  // lat: REQ cycle (1-based) carrying the ack; 0 or >TO means no ack at all.
  task automatic access(input logic rd, wr, input logic [31:0] addr, wd,
                        input int unsigned lat, input logic [31:0] rdv, input logic c0);
    logic legal, ill, al, acked, lv;
    int unsigned nreq;
    memread = rd; memwrite = wr; alu_result = addr; rdata2 = wd;
    branch = rand_en ? rbit() : 1'b0; zero = rand_en ? rbit() : 1'b0;
    mif.mem_ack = rand_en ? rbit() : 1'b0; mif.mem_rdata = $urandom; clr_err = c0;
    ill   = rd & wr;
    legal = (rd ^ wr) && (addr[1:0] == 2'b00);
    al    = (rd | wr) && !ill && (addr[1:0] != 2'b00);
    run_cycle(legal, branch & zero, 1'b0, 1'b0, ill, al, 1'b0, clr_err);
    if (legal) begin
      m_addr = addr; m_wd = wd; m_we = wr;
      acked = (lat >= 1) && (lat <= TO);
      nreq  = acked ? lat : TO;
      for (int unsigned i = 1; i <= nreq; i++) begin
        branch = rand_en ? rbit() : 1'b1; zero = rand_en ? rbit() : 1'b1;
        mif.mem_ack   = acked && (i == nreq);
        mif.mem_rdata = mif.mem_ack ? rdv : $urandom;
        clr_err = rclr();
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, !acked && (i == nreq), clr_err);
      end
      lv = acked && !wr;
      if (lv) m_ld = rdv;
      branch = rand_en ? rbit() : 1'b1; zero = rand_en ? rbit() : 1'b1;
      mif.mem_ack = rand_en ? rbit() : 1'b0; mif.mem_rdata = $urandom;
      clr_err = rclr();
      run_cycle(1'b0, 1'b0, 1'b0, lv, 1'b0, 1'b0, 1'b0, clr_err);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s_req, s_st, s_lv;
    logic [31:0] a;
    logic rw;
    int unsigned lat;
    int k;

    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",   mif.mem_req,   0);
    check("rst_mem_we",    mif.mem_we,    0);
    check("rst_mem_addr",  mif.mem_addr,  32'h0);
    check("rst_mem_wdata", mif.mem_wdata, 32'h0);
    check("rst_load_data", load_data,     32'h0);
    check("rst_load_valid",load_valid,    0);
    check("rst_errs",      {err_align, err_illegal, err_timeout}, 0);
    check("rst_stall",     stall,         0);
    rst_n = 1'b1;

    // Minimal load
    s_req = cnt_req; s_st = cnt_stall; s_lv = cnt_lv;
    access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    check("t1_req_cycles",   cnt_req - s_req,   1);
    check("t1_stall_cycles", cnt_stall - s_st,  2);
    check("t1_lv_pulses",    cnt_lv - s_lv,     1);
    check("t1_load_data",    load_data,         32'hDEADBEEF);

    // Store acked on third REQ cycle
    s_req = cnt_req; s_st = cnt_stall; s_lv = cnt_lv;
    access(1'b0, 1'b1, 32'h20, 32'h12345678, 3, 32'h0, 1'b0);
    check("t2_req_cycles",   cnt_req - s_req,   3);
    check("t2_stall_cycles", cnt_stall - s_st,  4);
    check("t2_lv_pulses",    cnt_lv - s_lv,     0);
    check("t2_mem_wdata",    mif.mem_wdata,     32'h12345678);
    check("t2_mem_we",       mif.mem_we,        1);

    // Misaligned load, then clear
    s_req = cnt_req; s_st = cnt_stall;
    access(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b0);
    check("t3_req_cycles",   cnt_req - s_req,   0);
    check("t3_stall_cycles", cnt_stall - s_st,  0);
    check("t3_err_align",    err_align,         1);
    idle_cycle(1'b1);
    check("t3_err_align_clr", err_align,        0);

    // Timeout
    s_req = cnt_req; s_st = cnt_stall; s_lv = cnt_lv;
    access(1'b1, 1'b0, 32'h30, 32'h0, 0, 32'h0, 1'b0);
    check("t4_req_cycles",   cnt_req - s_req,   16);
    check("t4_stall_cycles", cnt_stall - s_st,  17);
    check("t4_lv_pulses",    cnt_lv - s_lv,     0);
    check("t4_err_timeout",  err_timeout,       1);
    check("t4_load_data",    load_data,         32'hDEADBEEF);

    // Ack on the timeout edge; clr_err in the start cycle clears the earlier timeout
    s_req = cnt_req;
    access(1'b1, 1'b0, 32'h34, 32'h0, TO, 32'hA5A50001, 1'b1);
    check("t5_req_cycles",   cnt_req - s_req,   16);
    check("t5_err_timeout",  err_timeout,       0);
    check("t5_load_data",    load_data,         32'hA5A50001);

    // Illegal and misaligned with simultaneous clr: illegal set wins, align stays 0
    access(1'b1, 1'b1, 32'h3, 32'h0, 1, 32'h0, 1'b1);
    check("t6_err_illegal",  err_illegal,       1);
    check("t6_err_align",    err_align,         0);

    // Branch resolution in IDLE
    memread = 1'b0; memwrite = 1'b0; branch = 1'b1; zero = 1'b1; mif.mem_ack = 1'b0; clr_err = 1'b0;
    #1;
    check("t7_pcsrc_taken",  pcsrc,             1);
    check("t7_flush_taken",  flush,             1);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    zero = 1'b0;
    #1;
    check("t7_pcsrc_nt",     pcsrc,             0);
    check("t7_flush_nt",     flush,             0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the second REQ cycle of a load
    memread = 1'b1; memwrite = 1'b0; alu_result = 32'h40; rdata2 = 32'h0;
    branch = 1'b0; zero = 1'b0; mif.mem_ack = 1'b0;
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_addr = 32'h40; m_wd = 32'h0; m_we = 1'b0;
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t8_req_async",    mif.mem_req,       0);
    memread = 1'b0;
    #1;
    check("t8_stall",        stall,             0);
    check("t8_mem_addr",     mif.mem_addr,      32'h0);
    check("t8_load_data",    load_data,         32'h0);
    check("t8_load_valid",   load_valid,        0);
    check("t8_err_illegal",  err_illegal,       0);
    m_we = 1'b0; m_addr = '0; m_wd = '0; m_ld = '0; m_ea = 1'b0; m_ei = 1'b0; m_et = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_req = cnt_req;
    access(1'b1, 1'b0, 32'h44, 32'h0, 2, 32'hCAFEF00D, 1'b0);
    check("t8_post_req",     cnt_req - s_req,   2);
    check("t8_post_ld",      load_data,         32'hCAFEF00D);

    // Randomized traffic
    rand_en = 1'b1;
    repeat (400) begin
      k = $urandom_range(0, 9);
      if (k < 2) begin
        idle_cycle(rclr());
      end else if (k == 2) begin
        access(1'b1, 1'b1, $urandom, $urandom, 1, $urandom, rclr());
      end else if (k == 3) begin
        a = $urandom; a[1:0] = 2'($urandom_range(1, 3)); rw = rbit();
        access(rw, !rw, a, $urandom, 1, $urandom, rclr());
      end else begin
        a = $urandom; a[1:0] = 2'b00; rw = rbit();
        if ($urandom_range(0, 5) == 0) lat = 0;
        else if ($urandom_range(0, 1) == 0) lat = $urandom_range(1, 3);
        else lat = $urandom_range(1, TO);
        access(rw, !rw, a, $urandom, lat, $urandom, rclr());
      end
    end

    exp_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
